// File: rtl/apb_timer_periph.sv
// rtl/apb_timer_periph.sv - APB timer: prescaled 32-bit up-counter with auto-reload compare and match interrupt
module apb_timer_periph #(
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PWDATA,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        timer_irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   en;
    logic                   opm;
    logic                   ie;
    logic                   mf;
    logic [CNT_WIDTH-1:0]   tcnt;
    logic [CNT_WIDTH-1:0]   arr;
    logic [PSC_WIDTH-1:0]   psc;
    logic [PSC_WIDTH-1:0]   psc_cnt;
    logic [31:0]            rdata_mux;
    logic [2:0]             reg_sel;
    logic                   setup_done;
    logic                   wr_en;
    logic                   wr_tcr;
    logic                   wr_psc;
    logic                   wr_arr;
    logic                   wr_tsr;
    logic                   clr;
    logic                   tick;
    logic                   match;
    logic                   unused_addr;

    assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        PREADY     = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                PREADY     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Writes commit at the end of the ACK cycle, and only if the master still holds the access.
    assign reg_sel    = PADDR[4:2];
    assign setup_done = (state == IDLE) && PSEL && PENABLE;
    assign wr_en      = (state == ACK) && PSEL && PENABLE && PWRITE;
    assign wr_tcr     = wr_en && (reg_sel == 3'd0);
    assign wr_psc     = wr_en && (reg_sel == 3'd2);
    assign wr_arr     = wr_en && (reg_sel == 3'd3);
    assign wr_tsr     = wr_en && (reg_sel == 3'd4);
    assign clr        = wr_tcr && PWDATA[1];

    // A CLR write swallows any tick on the same edge.
    assign tick  = en && (psc_cnt == psc) && !clr;
    assign match = tick && (tcnt == arr);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psc_cnt <= '0;
            tcnt    <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
            tcnt    <= '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt <= '0;
                tcnt    <= match ? '0 : tcnt + CNT_WIDTH'(1);
            end else begin
                psc_cnt <= psc_cnt + PSC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en  <= 1'b0;
            opm <= 1'b0;
            ie  <= 1'b0;
            mf  <= 1'b0;
            psc <= '0;
            arr <= '0;
        end else begin
            if (wr_tcr) begin
                en  <= PWDATA[0];
                opm <= PWDATA[2];
                ie  <= PWDATA[3];
            end else if (match && opm) begin
                en  <= 1'b0;
            end
            if (match) begin
                mf <= 1'b1;
            end else if (wr_tsr && PWDATA[0]) begin
                mf <= 1'b0;
            end
            if (wr_psc) begin
                psc <= PWDATA[PSC_WIDTH-1:0];
            end
            if (wr_arr) begin
                arr <= PWDATA[CNT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rdata_mux = 32'd0;
        case (reg_sel)
            3'd0:    rdata_mux = {28'd0, ie, opm, 1'b0, en};
            3'd1:    rdata_mux = 32'(tcnt);
            3'd2:    rdata_mux = 32'(psc);
            3'd3:    rdata_mux = 32'(arr);
            3'd4:    rdata_mux = {31'd0, mf};
            default: rdata_mux = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= 32'd0;
        end else if (setup_done) begin
            PRDATA <= PWRITE ? 32'd0 : rdata_mux;
        end
    end

    assign timer_irq = mf & ie;

endmodule

// File: tb/tb_apb_timer_periph.sv
// tb/tb_apb_timer_periph.sv - self-checking bench for apb_timer_periph
module tb_apb_timer_periph;

    localparam logic [31:0] A_TCR  = 32'h00;
    localparam logic [31:0] A_TCNT = 32'h04;
    localparam logic [31:0] A_PSC  = 32'h08;
    localparam logic [31:0] A_ARR  = 32'h0C;
    localparam logic [31:0] A_TSR  = 32'h10;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    apb_timer_periph dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .timer_irq (timer_irq)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit expired before the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timer state k enabled edges after a clear, from the prescale/reload arithmetic.
    function automatic logic [31:0] tcnt_model(input int unsigned k, input int unsigned p, input int unsigned a);
        return 32'((k / (p + 1)) % (a + 1));
    endfunction

    function automatic logic [31:0] mf_model(input int unsigned k, input int unsigned p, input int unsigned a);
        return ((k / (p + 1)) >= (a + 1)) ? 32'd1 : 32'd0;
    endfunction

    // Three-cycle transfer: SETUP, ACCESS, ACK. Called and returns #1 after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        check("pready_access", {31'd0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        check("pready_ack", {31'd0, PREADY}, 32'd1);
        rdata = PRDATA;
        @(posedge PCLK); #1;
        check("pready_after", {31'd0, PREADY}, 32'd0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        apb_xfer(1'b1, addr, data, rd);
        check("prdata_on_write", rd, 32'd0);
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        apb_xfer(1'b0, addr, 32'd0, rd);
        check(tag, rd, exp);
    endtask

    initial begin
        int unsigned p;
        int unsigned a;
        int unsigned n;
        logic        ie_b;
        logic [31:0] v;

        PRESET  = 1'b1;
        PADDR   = 32'd0;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PWDATA  = 32'd0;
        PSEL    = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_pready", {31'd0, PREADY}, 32'd0);
        check("reset_prdata", PRDATA, 32'd0);
        check("reset_irq", {31'd0, timer_irq}, 32'd0);
        PRESET = 1'b0;

        // APB timing, read-only TCNT, unmapped addresses
        apb_write(A_ARR, 32'h0000_0004);
        apb_read(A_ARR, 32'h0000_0004, "arr_readback");
        apb_write(A_TCNT, 32'h0000_1234);
        apb_read(A_TCNT, 32'd0, "tcnt_readonly");
        apb_write(32'h1C, 32'hFFFF_FFFF);
        apb_read(32'h14, 32'd0, "unmapped_read");
        apb_read(32'h18, 32'd0, "unmapped_after_write");

        // Periodic count: PSC=3, ARR=4, EN+IE
        apb_write(A_PSC, 32'd3);
        apb_write(A_TCR, 32'h9);
        for (int i = 0; i < 15; i++) begin
            apb_read(A_TCNT, tcnt_model(3 * i + 1, 3, 4), "periodic_tcnt");
            check("periodic_irq", {31'd0, timer_irq}, mf_model(3 * i + 3, 3, 4));
        end
        apb_write(A_TCR, 32'h0);

        // One-shot: PSC=0, ARR=2
        apb_write(A_TSR, 32'h1);
        apb_write(A_PSC, 32'd0);
        apb_write(A_ARR, 32'd2);
        apb_write(A_TCR, 32'h7);
        apb_read(A_TCNT, 32'd1, "oneshot_tcnt1");
        apb_read(A_TCR, 32'h4, "oneshot_en_cleared");
        apb_read(A_TCNT, 32'd0, "oneshot_tcnt_wrap");
        apb_read(A_TSR, 32'd1, "oneshot_mf");
        repeat (10) @(posedge PCLK);
        #1;
        apb_read(A_TCNT, 32'd0, "oneshot_hold");
        apb_write(A_TCR, 32'h7);
        @(posedge PCLK); #1;
        apb_read(A_TCNT, 32'd2, "oneshot_tcnt2");

        // W1C with no tick, then W1C colliding with a match tick
        apb_write(A_TCR, 32'h8);
        check("irq_mf_ie", {31'd0, timer_irq}, 32'd1);
        apb_write(A_TSR, 32'h0);
        check("w0_no_effect", {31'd0, timer_irq}, 32'd1);
        apb_write(A_TSR, 32'h1);
        check("w1c_irq", {31'd0, timer_irq}, 32'd0);
        apb_read(A_TSR, 32'd0, "w1c_mf");
        apb_write(A_ARR, 32'd0);
        apb_write(A_TCR, 32'hB);
        apb_write(A_TSR, 32'h1);
        check("w1c_vs_tick_irq", {31'd0, timer_irq}, 32'd1);
        apb_write(A_TCR, 32'h0);

        // CLR collision with TCNT=3 on the write edge
        apb_write(A_TSR, 32'h1);
        apb_write(A_ARR, 32'd100);
        apb_write(A_TCR, 32'h3);
        @(posedge PCLK); #1;
        apb_write(A_TCR, 32'h3);
        apb_read(A_TCNT, 32'd1, "clr_restart");
        apb_read(A_TCR, 32'h1, "clr_reads_zero");
        apb_read(A_TCNT, 32'd7, "clr_resume");

        // PSEL dropped during ACK: no register update
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_ARR; PWDATA = 32'h55;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("drop_pready", {31'd0, PREADY}, 32'd1);
        @(posedge PCLK); #1;
        check("drop_idle", {31'd0, PREADY}, 32'd0);
        apb_read(A_ARR, 32'd100, "drop_no_write");

        // Random register readback
        apb_write(A_TCR, 32'h0);
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            apb_write(A_PSC, v);
            apb_read(A_PSC, v & 32'h0000_FFFF, "rand_psc");
            v = $urandom;
            apb_write(A_ARR, v);
            apb_read(A_ARR, v, "rand_arr");
        end

        // Random timer runs against the arithmetic model
        for (int r = 0; r < 8; r++) begin
            p    = $urandom_range(0, 4);
            a    = $urandom_range(0, 6);
            n    = $urandom_range(0, 50);
            ie_b = 1'($urandom_range(0, 1));
            apb_write(A_TCR, 32'h0);
            apb_write(A_TSR, 32'h1);
            apb_write(A_PSC, p);
            apb_write(A_ARR, a);
            apb_write(A_TCR, {28'd0, ie_b, 3'b011});
            repeat (n) @(posedge PCLK);
            #1;
            apb_read(A_TCNT, tcnt_model(n + 1, p, a), "rand_tcnt");
            apb_read(A_TSR, mf_model(n + 4, p, a), "rand_mf");
            check("rand_irq", {31'd0, timer_irq}, mf_model(n + 6, p, a) & {31'd0, ie_b});
        end

        // Asynchronous reset mid-count with TCNT=7 and irq asserted
        apb_write(A_TCR, 32'h0);
        apb_write(A_TSR, 32'h1);
        apb_write(A_PSC, 32'd0);
        apb_write(A_ARR, 32'd7);
        apb_write(A_TCR, 32'hB);
        repeat (6) @(posedge PCLK);
        #1;
        apb_read(A_TCNT, 32'd7, "pre_reset_tcnt");
        check("pre_reset_irq", {31'd0, timer_irq}, 32'd1);
        check("pre_reset_prdata", PRDATA, 32'd7);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_reset_prdata", PRDATA, 32'd0);
        check("async_reset_pready", {31'd0, PREADY}, 32'd0);
        check("async_reset_irq", {31'd0, timer_irq}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        apb_read(A_TCR, 32'd0, "reset_tcr");
        apb_read(A_TCNT, 32'd0, "reset_tcnt");
        apb_read(A_PSC, 32'd0, "reset_psc");
        apb_read(A_ARR, 32'd0, "reset_arr");
        apb_read(A_TSR, 32'd0, "reset_tsr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
